// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared encodings, state enum and result helper for the iterative compare unit
package cmp_pkg;

    // Function select, as presented on cmp_fun
    typedef enum logic [1:0] {
        CMP_NOP = 2'b00,
        CMP_EQ  = 2'b01,
        CMP_GT  = 2'b10,
        CMP_LT  = 2'b11
    } cmp_fun_t;

    // Result codes, zero-extended onto cmp_out
    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_EQ   = 2'd1;
    localparam logic [1:0] RES_GT   = 2'd2;
    localparam logic [1:0] RES_LT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // Result code for a function given the final ordering; RES_NONE means the condition is false
    function automatic logic [1:0] cmp_result(input cmp_fun_t fun, input logic gt, input logic lt);
        logic [1:0] res;
        res = RES_NONE;
        case (fun)
            CMP_EQ:  res = (!gt && !lt) ? RES_EQ : RES_NONE;
            CMP_GT:  res = gt ? RES_GT : RES_NONE;
            CMP_LT:  res = lt ? RES_LT : RES_NONE;
            default: res = RES_NONE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmp_digit_slice.sv
// rtl/cmp_digit_slice.sv - combinational single-digit magnitude comparator with optional sign flip
module cmp_digit_slice #(
    parameter int DIGIT_WIDTH = 4
) (
    input  logic [DIGIT_WIDTH-1:0] a,
    input  logic [DIGIT_WIDTH-1:0] b,
    input  logic                   msb_signed,
    output logic                   gt,
    output logic                   lt
);

    // Inverting the sign bit maps two's-complement ordering onto unsigned ordering
    logic [DIGIT_WIDTH-1:0] flip;
    logic [DIGIT_WIDTH-1:0] a_eff;
    logic [DIGIT_WIDTH-1:0] b_eff;

    assign flip  = DIGIT_WIDTH'(msb_signed) << (DIGIT_WIDTH - 1);
    assign a_eff = a ^ flip;
    assign b_eff = b ^ flip;
    assign gt    = (a_eff > b_eff);
    assign lt    = (a_eff < b_eff);

endmodule

// File: rtl/cmp_iter_unit.sv
// rtl/cmp_iter_unit.sv - multi-cycle MSB-first digit-serial compare unit; CMP_ITER_EARLY_EXIT_EN enables early exit
module cmp_iter_unit
    import cmp_pkg::*;
#(
    parameter int IN_WIDTH      = 16,
    parameter int DIGIT_WIDTH   = 4,
    parameter int CMP_OUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_WIDTH-1:0]      in1,
    input  logic [IN_WIDTH-1:0]      in2,
    input  logic [1:0]               cmp_fun,
    input  logic                     cmp_signed,
    input  logic                     cmp_en,
    output logic                     in_ready,
    output logic [CMP_OUT_WIDTH-1:0] cmp_out,
    output logic                     cmp_flag,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int NUM_DIGITS = IN_WIDTH / DIGIT_WIDTH;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

    cmp_state_t                state_q;
    logic [IN_WIDTH-1:0]       op_a_q;
    logic [IN_WIDTH-1:0]       op_b_q;
    cmp_fun_t                  fun_q;
    logic                      sign_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      decided_q;
    logic                      gt_q;
    logic                      lt_q;
    logic [CMP_OUT_WIDTH-1:0]  cmp_out_q;
    logic                      cmp_flag_q;
    logic                      out_valid_q;

    logic [DIGIT_WIDTH-1:0]    digit_a;
    logic [DIGIT_WIDTH-1:0]    digit_b;
    logic                      msb_signed;
    logic                      dig_gt;
    logic                      dig_lt;
    logic                      decided_d;
    logic                      gt_d;
    logic                      lt_d;
    logic                      finish_busy;
    logic [1:0]                res_d;

    // Select the digit currently under comparison from both latched operands
    always_comb begin
        digit_a = '0;
        digit_b = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_a = op_a_q[i*DIGIT_WIDTH +: DIGIT_WIDTH];
                digit_b = op_b_q[i*DIGIT_WIDTH +: DIGIT_WIDTH];
            end
        end
    end

    // Only the most significant digit carries the sign bit
    assign msb_signed = sign_q && (idx_q == IDX_TOP);

    cmp_digit_slice #(
        .DIGIT_WIDTH (DIGIT_WIDTH)
    ) u_digit_slice (
        .a          (digit_a),
        .b          (digit_b),
        .msb_signed (msb_signed),
        .gt         (dig_gt),
        .lt         (dig_lt)
    );

    // First differing digit decides the ordering; later digits cannot override it
    always_comb begin
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        if (!decided_q && (dig_gt || dig_lt)) begin
            decided_d = 1'b1;
            gt_d      = dig_gt;
            lt_d      = dig_lt;
        end
`ifdef CMP_ITER_EARLY_EXIT_EN
        finish_busy = (idx_q == '0) || decided_d;
`else
        finish_busy = (idx_q == '0);
`endif
        res_d = cmp_result(fun_q, gt_d, lt_d);
    end

    // Control FSM with operand capture, digit walk and registered result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            fun_q       <= CMP_NOP;
            sign_q      <= 1'b0;
            idx_q       <= '0;
            decided_q   <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            cmp_out_q   <= '0;
            cmp_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmp_en) begin
                        op_a_q    <= in1;
                        op_b_q    <= in2;
                        fun_q     <= cmp_fun_t'(cmp_fun);
                        sign_q    <= cmp_signed;
                        idx_q     <= IDX_TOP;
                        decided_q <= 1'b0;
                        gt_q      <= 1'b0;
                        lt_q      <= 1'b0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    decided_q <= decided_d;
                    gt_q      <= gt_d;
                    lt_q      <= lt_d;
                    if (finish_busy) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        cmp_flag_q  <= (res_d != RES_NONE);
                        cmp_out_q   <= CMP_OUT_WIDTH'(res_d);
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        cmp_flag_q  <= 1'b0;
                        cmp_out_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // in_ready is forced low while reset is held, independent of the state register
    assign in_ready  = rst && (state_q == IDLE);
    assign cmp_out   = cmp_out_q;
    assign cmp_flag  = cmp_flag_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cmp_iter_unit.sv
// tb/tb_cmp_iter_unit.sv - randomized self-checking bench for cmp_iter_unit against a behavioural model
module tb_cmp_iter_unit;

    localparam int W  = 16;
    localparam int DW = 4;
    localparam int OW = 16;
    localparam int ND = W / DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic [1:0]    cmp_fun;
    logic          cmp_signed;
    logic          cmp_en;
    logic          in_ready;
    logic [OW-1:0] cmp_out;
    logic          cmp_flag;
    logic          out_valid;
    logic          out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    cmp_iter_unit #(
        .IN_WIDTH      (W),
        .DIGIT_WIDTH   (DW),
        .CMP_OUT_WIDTH (OW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in1        (in1),
        .in2        (in2),
        .cmp_fun    (cmp_fun),
        .cmp_signed (cmp_signed),
        .cmp_en     (cmp_en),
        .in_ready   (in_ready),
        .cmp_out    (cmp_out),
        .cmp_flag   (cmp_flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected result and latency straight from the comparison rules
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] fun,
                         input logic sgn, output logic [1:0] code, output logic flag, output int lat);
        logic gt;
        logic lt;
        logic found;
        logic [W-1:0] sh_a;
        logic [W-1:0] sh_b;
        gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
        lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        flag = ((fun == 2'd1) && !gt && !lt) || ((fun == 2'd2) && gt) || ((fun == 2'd3) && lt);
        code = flag ? fun : 2'd0;
        lat = ND;
`ifdef CMP_ITER_EARLY_EXIT_EN
        found = 1'b0;
        for (int d = ND - 1; d >= 0; d--) begin
            sh_a = a >> (d * DW);
            sh_b = b >> (d * DW);
            if (!found && (sh_a[DW-1:0] != sh_b[DW-1:0])) begin
                found = 1'b1;
                lat = ND - d;
            end
        end
`else
        found = 1'b0;
        sh_a = a;
        sh_b = b;
`endif
    endtask

    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] fun,
                          input logic sgn, input int hold);
        logic [1:0] e_code;
        logic e_flag;
        int e_lat;
        int lat;
        model(a, b, fun, sgn, e_code, e_flag, e_lat);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in1 = a; in2 = b; cmp_fun = fun; cmp_signed = sgn; cmp_en = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        cmp_en = 1'b0;
        in1 = W'($urandom); in2 = W'($urandom);
        cmp_fun = 2'($urandom); cmp_signed = 1'($urandom);
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, e_lat);
        check("cmp_out", cmp_out, 64'(e_code));
        check("cmp_flag", cmp_flag, e_flag);
        for (int k = 0; k < hold; k++) begin
            cmp_en = 1'b1;
            in1 = W'($urandom); in2 = W'($urandom); cmp_fun = 2'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_out", cmp_out, 64'(e_code));
            check("hold_flag", cmp_flag, e_flag);
            check("hold_in_ready", in_ready, 0);
        end
        cmp_en = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("handoff_valid", out_valid, 0);
        check("handoff_out", cmp_out, 0);
        check("handoff_flag", cmp_flag, 0);
        check("handoff_in_ready", in_ready, 1);
    endtask

    task automatic reset_mid_busy();
        @(negedge clk);
        in1 = 16'h1234; in2 = 16'h1235; cmp_fun = 2'd3; cmp_signed = 1'b0; cmp_en = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_out", cmp_out, 0);
        check("rst_flag", cmp_flag, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_valid", out_valid, 0);
            check("post_rst_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] mask;
        rst = 1'b0;
        in1 = '0; in2 = '0; cmp_fun = 2'd0; cmp_signed = 1'b0; cmp_en = 1'b0; out_ready = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_valid", out_valid, 0);
        check("reset_out", cmp_out, 0);
        check("reset_flag", cmp_flag, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_req(16'd15, 16'd15, 2'd1, 1'b0, 0);
        do_req(16'd17, 16'd15, 2'd2, 1'b0, 0);
        do_req(16'd17, 16'd15, 2'd3, 1'b0, 0);
        do_req(16'hFFFF, 16'h0001, 2'd3, 1'b1, 0);
        do_req(16'hFFFF, 16'h0001, 2'd3, 1'b0, 0);
        do_req(16'h8000, 16'h7FFF, 2'd2, 1'b1, 0);
        do_req(16'h1234, 16'h1234, 2'd1, 1'b0, 5);
        do_req(16'hABCD, 16'h0F0F, 2'd2, 1'b0, 0);
        reset_mid_busy();
        do_req(16'hABCD, 16'h1234, 2'd0, 1'b0, 0);
        do_req(16'h0000, 16'h0000, 2'd0, 1'b1, 0);
        do_req(16'h5555, 16'h5556, 2'd3, 1'b0, 0);

        for (int t = 0; t < 80; t++) begin
            a = W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                b = W'($urandom);
            end else begin
                b = a;
                for (int d = 0; d < ND; d++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        mask = W'({DW{1'b1}}) << (d * DW);
                        b = (b & ~mask) | (W'($urandom) & mask);
                    end
                end
            end
            do_req(a, b, 2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmp_iter_unit.md
Name: cmp_iter_unit

Overview:
- Parametrised, multi-cycle successor to the team's single-cycle compare unit, for use in the ALU compare path.
- Latches two IN_WIDTH operands, then compares them MSB-first, DIGIT_WIDTH bits per cycle, with optional two's-complement mode.
- Uses a valid/ready handshake on input and output, so wide operands close timing without a full-width comparator.
- Result encoding matches the existing compare unit: 1 = EQ, 2 = GT, 3 = LT, 0 = false/NOP.

Parameters:
- IN_WIDTH, 16: operand width; must be a multiple of DIGIT_WIDTH.
- DIGIT_WIDTH, 4: bits compared per cycle.
- CMP_OUT_WIDTH, 16: width of cmp_out; the result code is zero-extended.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in1  in  IN_WIDTH  operand A.
- in2  in  IN_WIDTH  operand B.
- cmp_fun  in  2  function select: 00 NOP, 01 EQ, 10 GT, 11 LT.
- cmp_signed  in  1  1 = treat operands as two's complement.
- cmp_en  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- cmp_out  out  CMP_OUT_WIDTH  result code.
- cmp_flag  out  1  selected condition true.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Derived constant: NUM_DIGITS = IN_WIDTH/DIGIT_WIDTH.
- Reset (rst low, asynchronous):
  - state = IDLE, digit index = 0, decided = 0.
  - in_ready = 0 while rst is low, then 1 in IDLE.
  - cmp_out = 0, cmp_flag = 0, out_valid = 0.
  - Assertion mid-operation aborts the operation. No result is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On cmp_en=1 at an edge: latch in1, in2, cmp_fun, cmp_signed; set idx = NUM_DIGITS-1; clear decided/gt/lt; go to BUSY.
- BUSY:
  - in_ready = 0. Each cycle compares digit idx of A against digit idx of B.
  - If cmp_signed=1 and idx = NUM_DIGITS-1, the top bit of each digit is inverted before an unsigned compare.
  - The first differing digit sets decided=1 and gt or lt. Later digits never change a decided result.
  - If idx = 0, or decided is set under early exit, go to DONE. Otherwise decrement idx.
- Latency:
  - Fixed mode: out_valid rises NUM_DIGITS edges after the accept edge (4 at defaults).
  - Every cmp_fun runs the full sequence, including NOP.
- DONE:
  - out_valid = 1.
  - cmp_flag = (fun=EQ and equal) or (fun=GT and gt) or (fun=LT and lt).
  - cmp_out = code of fun when cmp_flag=1, else 0. NOP gives cmp_out = 0 and cmp_flag = 0.
  - Outputs are held stable while out_ready = 0.
  - On out_ready=1: go to IDLE; out_valid, cmp_out and cmp_flag clear on that edge.
- Simultaneous events:
  - cmp_en is ignored outside IDLE.
  - No accept occurs in the same cycle as result hand-off; the minimum request spacing is latency + 2 cycles.
- Input stability: in1, in2 and cmp_fun may change after acceptance without effect.

Optional Feature:
- Macro: CMP_ITER_EARLY_EXIT_EN.
- Defined:
  - BUSY goes to DONE in the same cycle the first differing digit is found.
  - Latency = position of the first differing digit counted from the MSB (1..NUM_DIGITS).
  - Equal operands still take NUM_DIGITS cycles.
- Undefined: fixed latency of NUM_DIGITS cycles, as described above.
- Result values are identical in both builds.

Decomposition:
- Package cmp_pkg holds:
  - the cmp_fun encodings (CMP_NOP, CMP_EQ, CMP_GT, CMP_LT);
  - the result codes (RES_NONE = 0, RES_EQ = 1, RES_GT = 2, RES_LT = 3);
  - the state enum (IDLE, BUSY, DONE).
- Sub-module cmp_digit_slice: a combinational DIGIT_WIDTH comparator.
  - Inputs: a, b, msb_signed.
  - Outputs: gt, lt.
  - Instantiated once and fed by a digit mux.
- The top level holds the FSM, operand registers, index counter and output registers.

Test Plan:
1. in1=15, in2=15, fun=01, unsigned, out_ready=1: out_valid rises 4 edges after accept; cmp_out=1, cmp_flag=1.
2. in1=17, in2=15, fun=10: cmp_out=2, cmp_flag=1. Latency is 4 without the macro and 3 with CMP_ITER_EARLY_EXIT_EN; fun=11 on the same operands gives cmp_out=0, cmp_flag=0.
3. in1=16'hFFFF, in2=16'h0001, fun=11: with cmp_signed=1, cmp_out=3 and cmp_flag=1; with cmp_signed=0, cmp_out=0 and cmp_flag=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing cmp_en with new operands.
   - Outputs stay unchanged and in_ready stays 0.
   - After out_ready=1, the next cmp_en is accepted with the new operands.
5. Assert rst low during BUSY (second cycle):
   - All outputs clear immediately.
   - After release, in_ready=1 and no stale out_valid appears.
6. fun=00 (NOP) with any operands: out_valid rises after 4 cycles with cmp_out=0, cmp_flag=0. Back-to-back requests complete in order.
